// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: ALU operations, instruction fields, mux selects and FSM states.
package alu_ctrl_pkg;

  localparam int unsigned OPW    = 6;
  localparam int unsigned ALUOPW = 4;
  localparam int unsigned STW    = 4;

  localparam logic [ALUOPW-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALUOPW-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALUOPW-1:0] ALU_AND = 4'b0100;
  localparam logic [ALUOPW-1:0] ALU_OR  = 4'b0101;
  localparam logic [ALUOPW-1:0] ALU_XOR = 4'b0110;
  localparam logic [ALUOPW-1:0] ALU_NOR = 4'b0111;
  localparam logic [ALUOPW-1:0] ALU_SLT = 4'b1010;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPW-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPW-1:0] OP_XORI  = 6'b001110;

  localparam logic [OPW-1:0] FN_ADD = 6'b100000;
  localparam logic [OPW-1:0] FN_SUB = 6'b100010;
  localparam logic [OPW-1:0] FN_AND = 6'b100100;
  localparam logic [OPW-1:0] FN_OR  = 6'b100101;
  localparam logic [OPW-1:0] FN_XOR = 6'b100110;
  localparam logic [OPW-1:0] FN_NOR = 6'b100111;
  localparam logic [OPW-1:0] FN_SLT = 6'b101010;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [STW-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_LW_WB   = 4'd4,
    S_MEM_WR  = 4'd5,
    S_R_EXEC  = 4'd6,
    S_R_WB    = 4'd7,
    S_I_EXEC  = 4'd8,
    S_I_WB    = 4'd9,
    S_BEQ     = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  function automatic logic opcode_legal(input logic [OPW-1:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: opcode_legal = 1'b1;
      default:                           opcode_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_funct_decoder.sv
// R-type funct field to ALUop translation; valid_c_o flags a supported funct.
module alu_funct_decoder
  import alu_ctrl_pkg::*;
(
  input  logic [OPW-1:0]    funct_i,
  output logic [ALUOPW-1:0] alu_op_c_o,
  output logic              valid_c_o
);

  always_comb begin
    alu_op_c_o = ALU_ADD;
    valid_c_o  = 1'b1;
    case (funct_i)
      FN_ADD:  alu_op_c_o = ALU_ADD;
      FN_SUB:  alu_op_c_o = ALU_SUB;
      FN_AND:  alu_op_c_o = ALU_AND;
      FN_OR:   alu_op_c_o = ALU_OR;
      FN_XOR:  alu_op_c_o = ALU_XOR;
      FN_NOR:  alu_op_c_o = ALU_NOR;
      FN_SLT:  alu_op_c_o = ALU_SLT;
      default: valid_c_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath enables.
module multicycle_control
  import alu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [OPW-1:0]    opcode,
  input  logic [OPW-1:0]    funct,
  input  logic              zero,
  output logic [ALUOPW-1:0] ALUop,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic              ext_zero,
  output logic              pc_en,
  output logic [1:0]        pc_src,
  output logic              iord,
  output logic              mem_write,
  output logic              ir_write,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              illegal
);

  state_e              state_q, state_d;
  logic [ALUOPW-1:0]   fn_alu_op;
  logic                fn_valid;

  alu_funct_decoder u_funct_dec (
    .funct_i    (funct),
    .alu_op_c_o (fn_alu_op),
    .valid_c_o  (fn_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                          state_d = S_R_EXEC;
          OP_LW, OP_SW:                      state_d = S_MEM_ADR;
          OP_BEQ:                            state_d = S_BEQ;
          OP_J:                              state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_I_EXEC;
          default:                           state_d = S_FETCH;
        endcase
      end
      S_MEM_ADR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  state_d = S_LW_WB;
      S_R_EXEC:  state_d = fn_valid ? S_R_WB : S_FETCH;
      S_I_EXEC:  state_d = S_I_WB;
      default:   state_d = S_FETCH;
    endcase
  end

  // While reset is held every strobe stays low even though the state already reads FETCH.
  always_comb begin
    ALUop      = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    ext_zero   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = PCSRC_ALU;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          ir_write  = 1'b1;
          alu_src_b = SRCB_FOUR;
          pc_en     = 1'b1;
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM4;
          illegal   = !opcode_legal(opcode);
        end
        S_MEM_ADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: iord = 1'b1;
        S_LW_WB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        S_MEM_WR: begin
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          ALUop     = fn_alu_op;
          illegal   = !fn_valid;
        end
        S_R_WB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          ext_zero  = (opcode != OP_ADDI);
          case (opcode)
            OP_ANDI: ALUop = ALU_AND;
            OP_ORI:  ALUop = ALU_OR;
            OP_XORI: ALUop = ALU_XOR;
            default: ALUop = ALU_ADD;
          endcase
        end
        S_I_WB: reg_write = 1'b1;
        S_BEQ: begin
          alu_src_a = 1'b1;
          ALUop     = ALU_SUB;
          pc_src    = PCSRC_ALUOUT;
          pc_en     = zero;
        end
        S_JUMP: begin
          pc_src = PCSRC_JUMP;
          pc_en  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction stream checked cycle by cycle against a per-instruction-class control table.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] aluop;
    logic       src_a;
    logic [1:0] src_b;
    logic       ext_zero;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero;
  logic [3:0] ALUop;
  logic       alu_src_a, ext_zero, pc_en, iord, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, illegal;
  logic [1:0] alu_src_b, pc_src;
  ctl_t       obs;

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0] legal_ops [9];
  logic [5:0] legal_fns [7];

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .ALUop(ALUop), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
    .pc_en(pc_en), .pc_src(pc_src), .iord(iord), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign obs = {ALUop, alu_src_a, alu_src_b, ext_zero, pc_en, pc_src, iord,
                mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Supported R-type functs and the ALU operation each one selects.
  function automatic logic [4:0] r_op(input logic [5:0] fn);
    case (fn)
      6'b100000: r_op = {1'b1, 4'b0000};
      6'b100010: r_op = {1'b1, 4'b0001};
      6'b100100: r_op = {1'b1, 4'b0100};
      6'b100101: r_op = {1'b1, 4'b0101};
      6'b100110: r_op = {1'b1, 4'b0110};
      6'b100111: r_op = {1'b1, 4'b0111};
      6'b101010: r_op = {1'b1, 4'b1010};
      default:   r_op = {1'b0, 4'b0000};
    endcase
  endfunction

  function automatic logic is_legal(input logic [5:0] opc);
    is_legal = 1'b0;
    foreach (legal_ops[i]) if (legal_ops[i] == opc) is_legal = 1'b1;
  endfunction

  function automatic logic is_itype(input logic [5:0] opc);
    is_itype = (opc == 6'b001000) || (opc == 6'b001100) || (opc == 6'b001101) || (opc == 6'b001110);
  endfunction

  function automatic int inst_len(input logic [5:0] opc, input logic [5:0] fn);
    logic [4:0] r;
    r = r_op(fn);
    if (opc == 6'b100011)                      inst_len = 5;
    else if (opc == 6'b101011 || is_itype(opc)) inst_len = 4;
    else if (opc == 6'b000000)                 inst_len = r[4] ? 4 : 3;
    else if (opc == 6'b000100 || opc == 6'b000010) inst_len = 3;
    else                                       inst_len = 2;
  endfunction

  function automatic ctl_t model(input logic [5:0] opc, input logic [5:0] fn,
                                 input int step, input logic z);
    ctl_t c;
    logic [4:0] r;
    c = '0;
    r = r_op(fn);
    if (step == 0) begin
      c.ir_write = 1'b1; c.src_b = 2'b01; c.pc_en = 1'b1;
    end else if (step == 1) begin
      c.src_b = 2'b11; c.illegal = !is_legal(opc);
    end else if (opc == 6'b100011 || opc == 6'b101011) begin
      if (step == 2) begin c.src_a = 1'b1; c.src_b = 2'b10; end
      else if (step == 3) begin c.iord = 1'b1; c.mem_write = (opc == 6'b101011); end
      else begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
    end else if (opc == 6'b000000) begin
      if (step == 2) begin
        c.src_a = 1'b1; c.aluop = r[3:0]; c.illegal = !r[4];
      end else begin
        c.reg_dst = 1'b1; c.reg_write = 1'b1;
      end
    end else if (is_itype(opc)) begin
      if (step == 2) begin
        c.src_a = 1'b1; c.src_b = 2'b10; c.ext_zero = (opc != 6'b001000);
        case (opc)
          6'b001100: c.aluop = 4'b0100;
          6'b001101: c.aluop = 4'b0101;
          6'b001110: c.aluop = 4'b0110;
          default:   c.aluop = 4'b0000;
        endcase
      end else c.reg_write = 1'b1;
    end else if (opc == 6'b000100) begin
      c.src_a = 1'b1; c.aluop = 4'b0001; c.pc_src = 2'b01; c.pc_en = z;
    end else if (opc == 6'b000010) begin
      c.pc_src = 2'b10; c.pc_en = 1'b1;
    end
    model = c;
  endfunction

  // Runs one instruction from FETCH; zmode < 0 randomizes zero every cycle.
  task automatic run_inst(input logic [5:0] opc, input logic [5:0] fn, input int zmode, input int idx);
    int   len;
    ctl_t e, g;
    logic [4:0] r;
    len = inst_len(opc, fn);
    r   = r_op(fn);
    for (int step = 0; step < len; step++) begin
      @(negedge clk);
      if (step == 0) begin opcode = opc; funct = fn; end
      zero = (zmode < 0) ? 1'($urandom) : 1'(zmode);
      #1;
      e = model(opc, fn, step, zero);
      g = obs;
      if (opc == 6'b000000 && step == 2 && !r[4]) g.aluop = e.aluop;
      check($sformatf("i%0d op=%b fn=%b step%0d ctl", idx, opc, fn, step), 32'(g), 32'(e));
      check($sformatf("i%0d step%0d one_write", idx, step),
            32'($countones({mem_write, reg_write, ir_write}) <= 1), 32'd1);
    end
  endtask

  initial begin
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                  6'b001000, 6'b001100, 6'b001101, 6'b001110};
    legal_fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                  6'b100110, 6'b100111, 6'b101010};
    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("reset_outputs", 32'(obs), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 300; i++) begin
      logic [5:0] opc, fn;
      int sel;
      sel = $urandom_range(0, 11);
      opc = (sel < 9) ? legal_ops[sel] : 6'($urandom);
      fn  = ($urandom_range(0, 9) < 7) ? legal_fns[$urandom_range(0, 6)] : 6'($urandom);
      run_inst(opc, fn, -1, i);
    end

    run_inst(6'b000000, 6'b100111, -1, 1000);
    run_inst(6'b100011, 6'b000000, -1, 1001);
    run_inst(6'b000100, 6'b000000,  1, 1002);
    run_inst(6'b000100, 6'b000000,  0, 1003);
    run_inst(6'b001101, 6'b000000, -1, 1004);
    run_inst(6'b111111, 6'b000000, -1, 1005);
    run_inst(6'b000000, 6'b111111, -1, 1006);

    // Abort a store in MEM_WR with reset.
    @(negedge clk);
    opcode = 6'b101011;
    repeat (3) @(negedge clk);
    #1 check("sw_memwr_before_reset", 32'(mem_write), 32'd1);
    #1 reset = 1'b1;
    #1 check("sw_abort_outputs", 32'(obs), 32'd0);
    @(posedge clk);
    #1 check("reset_held_outputs", 32'(obs), 32'd0);
    reset = 1'b0;
    #1 check("after_release_fetch", 32'(obs), 32'(model(6'b000000, 6'b000000, 0, 1'b0)));
    run_inst(6'b100011, 6'b000000, -1, 1007);
    run_inst(6'b000010, 6'b000000, -1, 1008);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
